// File: rtl/mem_req_initiator_if.sv
// Client request/response handshake and memory strobe bus for mem_req_initiator.
// The master modport is the initiator; the slave modport is the surrounding client and memory.
interface mem_req_initiator_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 14,
  parameter int RDATA_WIDTH = 8
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic [DATA_WIDTH-1:0]  req_wdata;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [RDATA_WIDTH-1:0] rsp_rdata;
  logic                   rsp_err;
  logic                   mem_re;
  logic                   mem_we;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0]  mem_wdata;
  logic [RDATA_WIDTH-1:0] mem_rdata;
  logic                   mem_resp;
  logic                   stray_resp;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_rdata, mem_resp,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_re, mem_we, mem_addr, mem_wdata,
           stray_resp
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_rdata, mem_resp,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_re, mem_we, mem_addr, mem_wdata,
           stray_resp
  );
endinterface

// File: rtl/mem_req_initiator.sv
// Single-outstanding memory request initiator: accepts a client request, strobes the
// memory until mem_resp or a wait timeout, then holds the response until the client takes it.
module mem_req_initiator #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 14,
  parameter int RDATA_WIDTH = 8,
  parameter int TIMEOUT     = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mem_req_initiator_if.master   bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

  state_t                 state;
  logic                   write_q;
  logic [7:0]             wait_cnt;
  logic                   mem_re_q;
  logic                   mem_we_q;
  logic [ADDR_WIDTH-1:0]  mem_addr_q;
  logic [DATA_WIDTH-1:0]  mem_wdata_q;
  logic [RDATA_WIDTH-1:0] rsp_rdata_q;
  logic                   rsp_err_q;
  logic                   stray_q;

  assign bus.req_ready  = (state == IDLE);
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.mem_re     = mem_re_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.stray_resp = stray_q;

  // A response that beats the timeout on its final cycle still counts as a normal completion.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      write_q     <= 1'b0;
      wait_cnt    <= 8'd0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      stray_q     <= 1'b0;
    end else begin
      if (bus.mem_resp && (state != ISSUE)) begin
        stray_q <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            write_q     <= bus.req_write;
            mem_addr_q  <= bus.req_addr;
            mem_wdata_q <= bus.req_wdata;
            mem_we_q    <= bus.req_write;
            mem_re_q    <= ~bus.req_write;
            wait_cnt    <= 8'd0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (bus.mem_resp) begin
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            rsp_rdata_q <= write_q ? '0 : bus.mem_rdata;
            rsp_err_q   <= 1'b0;
            state       <= RESP;
          end else if ((wait_cnt + 8'd1) == TIMEOUT_CNT) begin
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_initiator.sv
// Directed bench for mem_req_initiator with a response scoreboard: stimulus queues the
// expected response, a negedge monitor pops and compares on every rsp handshake.
module tb_mem_req_initiator;

  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
  } rsp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;
  rsp_t exp_q[$];
  rsp_t exp_item;

  mem_req_initiator_if #(.DATA_WIDTH(16), .ADDR_WIDTH(14), .RDATA_WIDTH(8)) bus ();

  mem_req_initiator #(
    .DATA_WIDTH(16), .ADDR_WIDTH(14), .RDATA_WIDTH(8), .TIMEOUT(15)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Presents one request and returns just after the acceptance edge.
  task automatic applyStimulus(input logic write, input logic [13:0] addr,
                               input logic [15:0] wdata);
    int n;
    bus.req_valid = 1'b1;
    bus.req_write = write;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      tick();
      n++;
    end
    checkOutput("req_ready_wait", {31'd0, bus.req_ready}, 32'd1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset_n && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_rsp: got rdata 0x%0h err %0b, expected no response",
                 bus.rsp_rdata, bus.rsp_err);
      end else begin
        exp_item = exp_q.pop_front();
        checkOutput("sb_rdata", {24'd0, bus.rsp_rdata}, {24'd0, exp_item.rdata});
        checkOutput("sb_err", {31'd0, bus.rsp_err}, {31'd0, exp_item.err});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n_re;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.mem_rdata = '0;
    bus.mem_resp  = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    checkOutput("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    checkOutput("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    checkOutput("rst_mem_re", {31'd0, bus.mem_re}, 32'd0);
    checkOutput("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    checkOutput("rst_mem_addr", {18'd0, bus.mem_addr}, 32'd0);
    checkOutput("rst_mem_wdata", {16'd0, bus.mem_wdata}, 32'd0);
    checkOutput("rst_rsp_rdata", {24'd0, bus.rsp_rdata}, 32'd0);
    checkOutput("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    checkOutput("rst_stray", {31'd0, bus.stray_resp}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Write 0x0005 <- 0xBEEF, memory completes during the first strobe cycle.
    exp_q.push_back('{rdata: 8'h00, err: 1'b0});
    applyStimulus(1'b1, 14'h0005, 16'hBEEF);
    checkOutput("wr_we_on", {31'd0, bus.mem_we}, 32'd1);
    checkOutput("wr_re_off", {31'd0, bus.mem_re}, 32'd0);
    checkOutput("wr_addr", {18'd0, bus.mem_addr}, 32'h0005);
    checkOutput("wr_wdata", {16'd0, bus.mem_wdata}, 32'hBEEF);
    checkOutput("wr_rsp_early", {31'd0, bus.rsp_valid}, 32'd0);
    checkOutput("wr_req_ready_busy", {31'd0, bus.req_ready}, 32'd0);
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 8'hAA;
    bus.rsp_ready = 1'b1;
    tick();
    bus.mem_resp = 1'b0;
    checkOutput("wr_we_off", {31'd0, bus.mem_we}, 32'd0);
    checkOutput("wr_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    checkOutput("wr_rsp_rdata", {24'd0, bus.rsp_rdata}, 32'd0);
    checkOutput("wr_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    tick();
    checkOutput("wr_back_idle", {31'd0, bus.req_ready}, 32'd1);
    checkOutput("wr_rsp_gone", {31'd0, bus.rsp_valid}, 32'd0);
    checkOutput("wr_addr_hold", {18'd0, bus.mem_addr}, 32'h0005);
    checkOutput("wr_wdata_hold", {16'd0, bus.mem_wdata}, 32'hBEEF);

    // Read 0x0003 after one wait cycle, then stall the response for 5 cycles.
    bus.rsp_ready = 1'b0;
    applyStimulus(1'b0, 14'h0003, 16'h1234);
    checkOutput("rd_re_on", {31'd0, bus.mem_re}, 32'd1);
    checkOutput("rd_we_off", {31'd0, bus.mem_we}, 32'd0);
    checkOutput("rd_addr", {18'd0, bus.mem_addr}, 32'h0003);
    tick();
    checkOutput("rd_re_wait", {31'd0, bus.mem_re}, 32'd1);
    checkOutput("rd_rsp_wait", {31'd0, bus.rsp_valid}, 32'd0);
    exp_q.push_back('{rdata: 8'h03, err: 1'b0});
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 8'h03;
    tick();
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = 8'hFF;
    checkOutput("rd_re_off", {31'd0, bus.mem_re}, 32'd0);
    checkOutput("rd_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    checkOutput("rd_rsp_rdata", {24'd0, bus.rsp_rdata}, 32'h03);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 14'h0007;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("stall_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      checkOutput("stall_rdata", {24'd0, bus.rsp_rdata}, 32'h03);
      checkOutput("stall_err", {31'd0, bus.rsp_err}, 32'd0);
      checkOutput("stall_req_ready", {31'd0, bus.req_ready}, 32'd0);
      checkOutput("stall_strobes", {30'd0, bus.mem_re, bus.mem_we}, 32'd0);
      checkOutput("stall_addr", {18'd0, bus.mem_addr}, 32'h0003);
    end
    bus.rsp_ready = 1'b1;
    tick();
    checkOutput("stall_release_ready", {31'd0, bus.req_ready}, 32'd1);
    checkOutput("stall_release_valid", {31'd0, bus.rsp_valid}, 32'd0);
    checkOutput("no_same_cycle_accept", {30'd0, bus.mem_re, bus.mem_we}, 32'd0);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    tick();

    // Read that never gets mem_resp: 15 strobe cycles then an error response.
    exp_q.push_back('{rdata: 8'h00, err: 1'b1});
    applyStimulus(1'b0, 14'h0010, 16'h0000);
    n_re = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.mem_re) n_re++;
      if (bus.rsp_valid) break;
      tick();
    end
    checkOutput("to_re_cycles", n_re, 32'd15);
    checkOutput("to_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    checkOutput("to_rsp_err", {31'd0, bus.rsp_err}, 32'd1);
    checkOutput("to_rsp_rdata", {24'd0, bus.rsp_rdata}, 32'd0);
    checkOutput("to_re_off", {31'd0, bus.mem_re}, 32'd0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // mem_resp on the very cycle the counter would hit the limit wins over the timeout.
    exp_q.push_back('{rdata: 8'h5A, err: 1'b0});
    applyStimulus(1'b0, 14'h0020, 16'h0000);
    for (int i = 0; i < 14; i++) tick();
    checkOutput("edge_still_issue", {31'd0, bus.mem_re}, 32'd1);
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 8'h5A;
    tick();
    bus.mem_resp = 1'b0;
    checkOutput("edge_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    checkOutput("edge_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    checkOutput("edge_rsp_rdata", {24'd0, bus.rsp_rdata}, 32'h5A);
    checkOutput("no_stray_yet", {31'd0, bus.stray_resp}, 32'd0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // Reset during ISSUE discards the transaction.
    applyStimulus(1'b0, 14'h0031, 16'h0000);
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checkOutput("rst_issue_strobes", {30'd0, bus.mem_re, bus.mem_we}, 32'd0);
    checkOutput("rst_issue_addr", {18'd0, bus.mem_addr}, 32'd0);
    checkOutput("rst_issue_ready", {31'd0, bus.req_ready}, 32'd1);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rst_issue_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    end
    bus.rsp_ready = 1'b0;

    // Reset during RESP discards the pending response.
    applyStimulus(1'b0, 14'h0032, 16'h0000);
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 8'h77;
    tick();
    bus.mem_resp = 1'b0;
    checkOutput("rst_resp_pending", {31'd0, bus.rsp_valid}, 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checkOutput("rst_resp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    checkOutput("rst_resp_rdata", {24'd0, bus.rsp_rdata}, 32'd0);
    tick();

    // Unsolicited mem_resp in IDLE sets the sticky flag until reset.
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 8'h99;
    tick();
    bus.mem_resp = 1'b0;
    checkOutput("stray_set", {31'd0, bus.stray_resp}, 32'd1);
    checkOutput("stray_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    checkOutput("stray_idle", {31'd0, bus.req_ready}, 32'd1);
    tick();
    tick();
    checkOutput("stray_sticky", {31'd0, bus.stray_resp}, 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checkOutput("stray_cleared", {31'd0, bus.stray_resp}, 32'd0);
    tick();

    checkOutput("sb_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
